// File: rtl/axis_uart_tx_arb.sv
// rtl/axis_uart_tx_arb.sv - round-robin arbiter of N byte streams onto one UART TX stream
// Optional source-header byte per packet; packets longer than MAX_BEATS are force-released.
module axis_uart_tx_arb #(
  parameter int          N_SRC     = 4,
  parameter int          HDR_EN    = 1,
  parameter logic [7:0]  HDR_BASE  = 8'hA0,
  parameter int          MAX_BEATS = 256
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_SRC-1:0]     s_tvalid,
  input  logic [8*N_SRC-1:0]   s_tdata,
  input  logic [N_SRC-1:0]     s_tlast,
  output logic [N_SRC-1:0]     s_tready,
  output logic                 m_tvalid,
  output logic [7:0]           m_tdata,
  input  logic                 m_tready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 trunc_err
);

  localparam int              CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [2:0]      LAST_IDX = 3'(N_SRC - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;

  logic             sel_vld, sel_last;
  logic [7:0]       sel_data;
  logic             req_found;
  logic [2:0]       req_idx;
  logic [2:0]       next_ptr;

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == 3'(i)) begin
        sel_vld  = s_tvalid[i];
        sel_last = s_tlast[i];
        sel_data = s_tdata[8*i +: 8];
      end
    end
  end

  // Scan starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    int idx;
    req_found = 1'b0;
    req_idx   = 3'd0;
    idx       = 0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!req_found && s_tvalid[idx]) begin
        req_found = 1'b1;
        req_idx   = 3'(idx);
      end
    end
  end

  assign next_ptr = (grant_q == LAST_IDX) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    trunc_d  = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    s_tready = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_found) begin
          grant_d = req_idx;
          state_d = (HDR_EN != 0) ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = HDR_BASE | {5'b00000, grant_q};
        if (m_tready) state_d = S_DATA;
      end
      S_DATA: begin
        m_tvalid = sel_vld;
        m_tdata  = sel_vld ? sel_data : 8'h00;
        for (int i = 0; i < N_SRC; i++) begin
          if (grant_q == 3'(i)) s_tready[i] = m_tready;
        end
        if (sel_vld && m_tready) begin
          cnt_d = cnt_q + 1'b1;
          // A tlast on the final allowed beat is a normal end, not a truncation.
          if (sel_last || (cnt_q + 1'b1) == CNT_MAX) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr;
            trunc_d  = !sel_last;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      grant_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign trunc_err = trunc_q;

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// tb/tb_axis_uart_tx_arb.sv - scoreboard bench for axis_uart_tx_arb
module tb_axis_uart_tx_arb;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_tvalid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tlast;
  logic        m_tready;

  logic [3:0]  s_tready_a, s_tready_b;
  logic        m_tvalid_a, m_tvalid_b;
  logic [7:0]  m_tdata_a, m_tdata_b;
  logic [2:0]  grant_id_a, grant_id_b;
  logic        busy_a, busy_b, trunc_err_a, trunc_err_b;

  logic        use_b;
  logic [3:0]  rdy;
  logic        mv, bsy, trn;
  logic [7:0]  md;
  logic [2:0]  gid;

  logic [8:0]  src_q [4][$];
  logic [7:0]  exp_q [$];
  logic [3:0]  acc = 4'b0000;
  logic        stall_q = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  int          tests = 0;
  int          fails = 0;
  int          trunc_cnt = 0;

  always #5 aclk = ~aclk;

  axis_uart_tx_arb #(.N_SRC(4), .HDR_EN(1), .HDR_BASE(8'hA0), .MAX_BEATS(4)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready_a), .m_tvalid(m_tvalid_a), .m_tdata(m_tdata_a), .m_tready(m_tready),
    .grant_id(grant_id_a), .busy(busy_a), .trunc_err(trunc_err_a));

  axis_uart_tx_arb #(.N_SRC(4), .HDR_EN(0), .HDR_BASE(8'hA0), .MAX_BEATS(256)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready_b), .m_tvalid(m_tvalid_b), .m_tdata(m_tdata_b), .m_tready(m_tready),
    .grant_id(grant_id_b), .busy(busy_b), .trunc_err(trunc_err_b));

  always_comb begin
    if (use_b) begin
      rdy = s_tready_b; mv = m_tvalid_b; md = m_tdata_b; gid = grant_id_b; bsy = busy_b; trn = trunc_err_b;
    end else begin
      rdy = s_tready_a; mv = m_tvalid_a; md = m_tdata_a; gid = grant_id_a; bsy = busy_a; trn = trunc_err_a;
    end
  end

  // Source driver: presents the head of each source queue, pops on accepted beats.
  initial begin
    logic [8:0] head;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    forever begin
      @(posedge aclk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_q[i].size() > 0) head = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          head = src_q[i][0];
          s_tvalid[i] = 1'b1;
          s_tdata[8*i +: 8] = head[7:0];
          s_tlast[i] = head[8];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tdata[8*i +: 8] = 8'h00;
          s_tlast[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge aclk);
      acc = s_tvalid & rdy;
      if (trn) trunc_cnt++;
      if (aresetn) begin
        if (!mv) begin
          tests++;
          if (md !== 8'h00) begin fails++; $display("FAIL idle_data: m_tdata=%h required 00", md); end
        end
        if (stall_q) begin
          tests++;
          if (mv !== 1'b1 || md !== stall_data) begin
            fails++; $display("FAIL stall_hold: m_tvalid=%b m_tdata=%h required 1/%h", mv, md, stall_data);
          end
        end
        tests++;
        if (((rdy & ~(4'b0001 << gid)) !== 4'b0000) ||
            (((rdy & (4'b0001 << gid)) != 4'b0000) && !m_tready)) begin
          fails++; $display("FAIL ready_route: s_tready=%b grant=%0d m_tready=%b", rdy, gid, m_tready);
        end
        if (mv && m_tready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL unexpected_byte: got %h required none", md);
          end else begin
            e = exp_q.pop_front();
            if (md !== e) begin fails++; $display("FAIL out_byte: got %h required %h", md, e); end
          end
        end
        stall_q    = mv && !m_tready;
        stall_data = md;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  function automatic bit srcs_pending();
    return (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) != 0;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #2;
    aresetn   = 1'b1;
    trunc_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || srcs_pending()) && n < budget) begin
      @(negedge aclk); #1; n++;
    end
    tests++;
    if (n >= budget) begin
      fails++; $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_exp_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge aclk); #1; n++;
    end
    tests++;
    if (n >= budget) begin
      fails++; $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    src_q[0].push_back({1'b1, 8'h99});
    repeat (3) @(posedge aclk);
    #2;
    tests++;
    if (m_tvalid_a !== 1'b0 || m_tdata_a !== 8'h00 || s_tready_a !== 4'b0 || busy_a !== 1'b0 ||
        trunc_err_a !== 1'b0 || grant_id_a !== 3'd0) begin
      fails++; $display("FAIL reset_a: v=%b d=%h r=%b busy=%b trunc=%b g=%0d required all zero",
                        m_tvalid_a, m_tdata_a, s_tready_a, busy_a, trunc_err_a, grant_id_a);
    end
    tests++;
    if (m_tvalid_b !== 1'b0 || m_tdata_b !== 8'h00 || s_tready_b !== 4'b0 || busy_b !== 1'b0 ||
        trunc_err_b !== 1'b0 || grant_id_b !== 3'd0) begin
      fails++; $display("FAIL reset_b: v=%b d=%h r=%b busy=%b trunc=%b g=%0d required all zero",
                        m_tvalid_b, m_tdata_b, s_tready_b, busy_b, trunc_err_b, grant_id_b);
    end
  endtask

  task automatic test_single();
    do_reset();
    m_tready = 1'b1;
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    src_q[0].push_back({1'b0, 8'hA5});
    src_q[0].push_back({1'b1, 8'h5A});
    @(posedge aclk); #2;
    tests++;
    if (mv !== 1'b0 || s_tvalid[0] !== 1'b1) begin
      fails++; $display("FAIL single_pre: m_tvalid=%b s_tvalid0=%b required 0/1", mv, s_tvalid[0]);
    end
    @(posedge aclk); #2;
    tests++;
    if (mv !== 1'b1 || md !== 8'hA0) begin
      fails++; $display("FAIL single_latency: m_tvalid=%b m_tdata=%h required 1/a0", mv, md);
    end
    wait_exp_empty("single", 20);
    tests++;
    if (bsy !== 1'b1) begin fails++; $display("FAIL single_busy_last: busy=%b required 1", bsy); end
    @(posedge aclk); #2;
    tests++;
    if (bsy !== 1'b0) begin fails++; $display("FAIL single_busy_drop: busy=%b required 0", bsy); end
  endtask

  task automatic test_contention();
    do_reset();
    m_tready = 1'b1;
    src_q[0].push_back({1'b1, 8'h11});
    src_q[0].push_back({1'b1, 8'h44});
    src_q[1].push_back({1'b1, 8'h22});
    src_q[3].push_back({1'b1, 8'h33});
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h22);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h33);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h44);
    wait_done("contention", 60);
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    m_tready = 1'b1;
    src_q[1].push_back({1'b0, 8'hC1});
    src_q[1].push_back({1'b0, 8'hC2});
    src_q[1].push_back({1'b1, 8'hC3});
    exp_q.push_back(8'hA1); exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    while ((exp_q.size() != 0 || srcs_pending()) && n < 40) begin
      @(posedge aclk); #2;
      m_tready = ~m_tready;
      n++;
    end
    tests++;
    if (n >= 40) begin fails++; $display("FAIL backpressure_timeout: %0d bytes outstanding, required 0", exp_q.size()); end
    m_tready = 1'b1;
  endtask

  task automatic test_truncation();
    do_reset();
    m_tready = 1'b1;
    for (int i = 1; i <= 6; i++) src_q[2].push_back({1'b0, 8'(i)});
    src_q[3].push_back({1'b1, 8'h3C});
    exp_q.push_back(8'hA2);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hA3); exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    wait_done("truncation", 80);
    tests++;
    if (trunc_cnt !== 1) begin fails++; $display("FAIL trunc_pulses: got %0d required 1", trunc_cnt); end
    tests++;
    if (bsy !== 1'b1 || gid !== 3'd2) begin
      fails++; $display("FAIL trunc_stall: busy=%b grant=%0d required 1/2", bsy, gid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_tready = 1'b1;
    src_q[0].push_back({1'b0, 8'hB1});
    src_q[0].push_back({1'b0, 8'hB2});
    src_q[0].push_back({1'b0, 8'hB3});
    src_q[0].push_back({1'b0, 8'hB4});
    src_q[0].push_back({1'b1, 8'hB5});
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
    wait_exp_empty("reset_mid", 20);
    @(posedge aclk); #2;
    tests++;
    if (mv !== 1'b1 || md !== 8'hB3) begin
      fails++; $display("FAIL reset_mid_pre: m_tvalid=%b m_tdata=%h required 1/b3", mv, md);
    end
    aresetn = 1'b0;
    #1;
    tests++;
    if (mv !== 1'b0 || md !== 8'h00 || bsy !== 1'b0 || rdy !== 4'b0 || gid !== 3'd0) begin
      fails++; $display("FAIL reset_mid_async: v=%b d=%h busy=%b r=%b g=%0d required 0", mv, md, bsy, rdy, gid);
    end
    for (int i = 0; i < 4; i++) src_q[i].delete();
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    src_q[1].push_back({1'b1, 8'h77});
    exp_q.push_back(8'hA1); exp_q.push_back(8'h77);
    wait_done("reset_mid_after", 20);
    tests++;
    if (gid !== 3'd1) begin fails++; $display("FAIL reset_mid_grant: got %0d required 1", gid); end
  endtask

  task automatic test_nohdr();
    use_b = 1'b1;
    do_reset();
    m_tready = 1'b1;
    src_q[1].push_back({1'b0, 8'hFF});
    src_q[1].push_back({1'b1, 8'h00});
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    @(posedge aclk); #2;
    tests++;
    if (mv !== 1'b0 || s_tvalid[1] !== 1'b1) begin
      fails++; $display("FAIL nohdr_pre: m_tvalid=%b s_tvalid1=%b required 0/1", mv, s_tvalid[1]);
    end
    @(posedge aclk); #2;
    tests++;
    if (mv !== 1'b1 || md !== 8'hFF) begin
      fails++; $display("FAIL nohdr_latency: m_tvalid=%b m_tdata=%h required 1/ff", mv, md);
    end
    wait_done("nohdr", 20);
    @(posedge aclk); #2;
    tests++;
    if (bsy !== 1'b0) begin fails++; $display("FAIL nohdr_busy: busy=%b required 0", bsy); end
    use_b = 1'b0;
  endtask

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b1;
    use_b    = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_truncation();
    test_reset_mid();
    test_nohdr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
